// File: rtl/check_node_serial.sv
// Serial sum-product check-node processor: collects DC phi-mapped messages,
// then streams DC extrinsic check-to-variable messages in arrival order.
module check_node_serial #(
    parameter int DC = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_msg,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_msg,
    output logic [2:0] out_idx,
    output logic       out_last
);

    typedef enum logic [1:0] {
        COLLECT,
        CALC,
        EMIT
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(DC - 1);

    function automatic logic [3:0] phi(input logic [6:0] x);
        logic [3:0] r;
        if (x == 7'd0)       r = 4'd15;
        else if (x == 7'd1)  r = 4'd8;
        else if (x == 7'd2)  r = 4'd6;
        else if (x == 7'd3)  r = 4'd4;
        else if (x == 7'd4)  r = 4'd3;
        else if (x <= 7'd6)  r = 4'd2;
        else if (x <= 7'd11) r = 4'd1;
        else                 r = 4'd0;
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] sum_q, sum_d;
    logic       parity_q, parity_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_msg_q, out_msg_d;
    logic [2:0] out_idx_q, out_idx_d;
    logic       out_last_q, out_last_d;

    // Sized to the full 3-bit index range so any legal DC indexes it safely.
    logic [3:0] phi_buf_q  [8];
    logic       sign_buf_q [8];

    logic       accept;
    logic [3:0] phi_in;
    logic [2:0] res_idx;
    logic [6:0] ext;
    logic [7:0] res_msg;

    assign accept  = (state_q == COLLECT) && in_valid;
    assign phi_in  = phi(in_msg[6:0]);
    assign res_idx = (state_q == EMIT) ? out_idx_q + 3'd1 : 3'd0;
    assign ext     = sum_q - {3'b000, phi_buf_q[res_idx]};
    assign res_msg = {parity_q ^ sign_buf_q[res_idx], 3'b000, phi(ext)};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        parity_d    = parity_q;
        out_valid_d = out_valid_q;
        out_msg_d   = out_msg_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    sum_d    = sum_q + {3'b000, phi_in};
                    parity_d = parity_q ^ in_msg[7];
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_q == LAST_IDX) state_d = CALC;
                end
            end
            CALC: begin
                out_valid_d = 1'b1;
                out_msg_d   = res_msg;
                out_idx_d   = 3'd0;
                out_last_d  = 1'b0;
                state_d     = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        sum_d       = 7'd0;
                        parity_d    = 1'b0;
                        cnt_d       = 3'd0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = COLLECT;
                    end else begin
                        out_msg_d  = res_msg;
                        out_idx_d  = res_idx;
                        out_last_d = (res_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= 3'd0;
            sum_q       <= 7'd0;
            parity_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_msg_q   <= 8'd0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            parity_q    <= parity_d;
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    // Edge buffer needs no reset: every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            phi_buf_q[cnt_q]  <= phi_in;
            sign_buf_q[cnt_q] <= in_msg[7];
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = out_valid_q;
    assign out_msg   = out_msg_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_check_node_serial.sv
// Directed-vector bench for check_node_serial at DC=6: frame table plus
// stall, gap, back-to-back and mid-frame reset sequences.
module tb_check_node_serial;

    localparam int DC = 6;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_msg;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_msg;
    logic [2:0] out_idx;
    logic       out_last;

    int tests;
    int fails;

    check_node_serial #(.DC(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed arrays are listed element 5 first, element 0 last.
    typedef struct packed {
        logic [5:0][7:0] in_m;
        logic [5:0][7:0] exp_m;
        logic            gaps;
        logic [2:0]      hold_idx;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input int v);
        int budget;
        for (int i = 0; i < DC; i++) begin
            if (vecs[v].gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_msg   = vecs[v].in_m[i];
            budget   = 0;
            while (!in_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            chk("in_ready_collect", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_msg   = 8'h00;
        end
        chk("calc_out_valid", 32'(out_valid), 32'd0);
        chk("calc_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
    endtask

    task automatic recv_frame(input int v, input int n_out);
        int budget;
        for (int i = 0; i < n_out; i++) begin
            @(negedge clk);
            chk("out_valid_no_bubble", 32'(out_valid), 32'd1);
            budget = 0;
            while (!out_valid && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            chk("out_msg", 32'(out_msg), 32'(vecs[v].exp_m[i]));
            chk("out_idx", 32'(out_idx), 32'(i));
            chk("out_last", 32'(out_last), 32'(i == DC - 1));
            chk("in_ready_emit", 32'(in_ready), 32'd0);
            if (i == int'(vecs[v].hold_idx)) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("hold_out_msg", 32'(out_msg), 32'(vecs[v].exp_m[i]));
                    chk("hold_out_idx", 32'(out_idx), 32'(i));
                    chk("hold_out_valid", 32'(out_valid), 32'd1);
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            if (i == DC - 1) begin
                chk("return_in_ready", 32'(in_ready), 32'd1);
                chk("return_out_valid", 32'(out_valid), 32'd0);
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_msg    = 8'h00;
        out_ready = 1'b1;

        vecs[0] = '{in_m: {6{8'h08}}, exp_m: {6{8'h02}}, gaps: 1'b0, hold_idx: 3'd2};
        vecs[1] = '{in_m: {8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00},
                    exp_m: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F}, gaps: 1'b0, hold_idx: 3'd7};
        vecs[2] = '{in_m: {8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h88},
                    exp_m: {8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h02}, gaps: 1'b0, hold_idx: 3'd7};
        vecs[3] = '{in_m: {8'h07, 8'h01, 8'h0C, 8'h8C, 8'h8C, 8'h0C},
                    exp_m: {8'h01, 8'h08, 8'h01, 8'h81, 8'h81, 8'h01}, gaps: 1'b0, hold_idx: 3'd7};
        vecs[4] = '{in_m: {8'h94, 8'h8B, 8'h86, 8'h84, 8'h83, 8'h82},
                    exp_m: {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h81}, gaps: 1'b0, hold_idx: 3'd7};
        vecs[5] = '{in_m: {6{8'h08}}, exp_m: {6{8'h02}}, gaps: 1'b1, hold_idx: 3'd7};
        vecs[6] = '{in_m: {8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h88},
                    exp_m: {8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h02}, gaps: 1'b0, hold_idx: 3'd7};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_msg", 32'(out_msg), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            send_frame(v);
            recv_frame(v, DC);
        end

        // Abort a frame after index 3 is taken, then check no residue survives.
        send_frame(1);
        recv_frame(1, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_msg", 32'(out_msg), 32'd0);
        chk("midrst_out_idx", 32'(out_idx), 32'd0);
        chk("midrst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(5);
        recv_frame(5, DC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
